// File: rtl/icache_if.sv
// Fetch-side and memory-side bus of the direct-mapped instruction cache.
// ICACHE_STATS_EN adds the hit_count/miss_count statistics signals.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
`else
  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );
  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
`endif
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a two-state miss FSM.
// Define ICACHE_STATS_EN to add saturating hit/miss counters.
module icache #(
  parameter int NSETS = 16
) (
  input  logic     CLK,
  input  logic     nRST,
  icache_if.slave  bus
);
  localparam int IDXW = $clog2(NSETS);
  localparam int TAGW = 30 - IDXW;

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t            state;
  logic              iren_r;
  logic [31:0]       miss_addr;
  logic [NSETS-1:0]  valid;
  logic [TAGW-1:0]   tags [NSETS];
  logic [31:0]       data [NSETS];

  logic [IDXW-1:0]   req_idx;
  logic [TAGW-1:0]   req_tag;
  logic [IDXW-1:0]   fill_idx;
  logic [TAGW-1:0]   fill_tag;
  logic              hit_s;
  logic              miss_s;
  logic              fill_s;
  logic              unused_s;

  assign req_idx  = bus.imemaddr[IDXW+1:2];
  assign req_tag  = bus.imemaddr[31:IDXW+2];
  assign fill_idx = miss_addr[IDXW+1:2];
  assign fill_tag = miss_addr[31:IDXW+2];
  assign unused_s = &{1'b0, bus.imemaddr[1:0], miss_addr[1:0]};

  // Lookup: a hit only counts in IDLE with a live request and no flush.
  always_comb begin
    hit_s  = 1'b0;
    miss_s = 1'b0;
    if (state == IDLE && bus.imemREN && !bus.flush) begin
      hit_s  = valid[req_idx] && (tags[req_idx] == req_tag);
      miss_s = !hit_s;
    end else begin
      hit_s  = 1'b0;
      miss_s = 1'b0;
    end
  end

  // A flush in the completing cycle wins: the fill is dropped.
  assign fill_s = (state == FETCH) && !bus.iwait && !bus.flush;

  assign bus.ihit     = hit_s;
  assign bus.imemload = hit_s ? data[req_idx] : 32'h0;
  assign bus.iREN     = iren_r;
  assign bus.iaddr    = {miss_addr[31:2], 2'b00};

  // Miss FSM, valid bits and the latched miss address.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      iren_r    <= 1'b0;
      miss_addr <= 32'h0;
      valid     <= '0;
    end else if (bus.flush) begin
      state  <= IDLE;
      iren_r <= 1'b0;
      valid  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_s) begin
            miss_addr <= bus.imemaddr;
            state     <= FETCH;
            iren_r    <= 1'b1;
          end
        end
        FETCH: begin
          if (!bus.iwait) begin
            valid[fill_idx] <= 1'b1;
            state           <= IDLE;
            iren_r          <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          iren_r <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data arrays carry no reset; valid alone qualifies them.
  always_ff @(posedge CLK) begin
    if (fill_s) begin
      tags[fill_idx] <= fill_tag;
      data[fill_idx] <= bus.iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_r;
  logic [31:0] miss_count_r;

  assign bus.hit_count  = hit_count_r;
  assign bus.miss_count = miss_count_r;

  // Saturating statistics; flush deliberately leaves them alone.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count_r  <= 32'h0;
      miss_count_r <= 32'h0;
    end else begin
      if (hit_s && hit_count_r != 32'hFFFF_FFFF) begin
        hit_count_r <= hit_count_r + 32'd1;
      end
      if (miss_s && miss_count_r != 32'hFFFF_FFFF) begin
        miss_count_r <= miss_count_r + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed, table-driven bench for icache (NSETS=16) plus hand-written
// sequences for reset mid-fill, variable memory latency and statistics.
module tb_icache;
  logic CLK;
  logic nRST;
  int   n_chk;
  int   n_pass;

  icache_if bus ();

  icache #(.NSETS(16)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren;
    logic [31:0] addr;
    logic        flush;
    logic        iwait;
    logic [31:0] iload;
    logic        e_hit;
    logic [31:0] e_load;
    logic        e_ren;
    logic [31:0] e_iaddr;
  } vec_t;

  vec_t vt [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ren, input logic [31:0] addr, input logic fl,
                       input logic iw, input logic [31:0] ld);
    bus.imemREN  = ren;
    bus.imemaddr = addr;
    bus.flush    = fl;
    bus.iwait    = iw;
    bus.iload    = ld;
  endtask

  initial begin
    int lat;
    int hit_cycle;
    logic [31:0] hit_word;
    n_chk  = 0;
    n_pass = 0;

    //         ren   addr   flush iwait iload          hit  load           iREN iaddr
    vt[0]  = '{1'b1, 32'h40,  1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
    vt[1]  = '{1'b1, 32'h40,  1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 32'h40};
    vt[2]  = '{1'b1, 32'h40,  1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 32'h40};
    vt[3]  = '{1'b1, 32'h40,  1'b0, 1'b0, 32'h8C220004, 1'b0, 32'h0,        1'b1, 32'h40};
    vt[4]  = '{1'b1, 32'h40,  1'b0, 1'b1, 32'h0,        1'b1, 32'h8C220004, 1'b0, 32'h40};
    vt[5]  = '{1'b1, 32'h42,  1'b0, 1'b1, 32'h0,        1'b1, 32'h8C220004, 1'b0, 32'h40};
    vt[6]  = '{1'b0, 32'h40,  1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h40};
    vt[7]  = '{1'b1, 32'h80,  1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h40};
    vt[8]  = '{1'b1, 32'h80,  1'b0, 1'b0, 32'h11111111, 1'b0, 32'h0,        1'b1, 32'h80};
    vt[9]  = '{1'b1, 32'h80,  1'b0, 1'b1, 32'h0,        1'b1, 32'h11111111, 1'b0, 32'h80};
    vt[10] = '{1'b1, 32'h40,  1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h80};
    vt[11] = '{1'b1, 32'h100, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b1, 32'h40};
    vt[12] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h22222222, 1'b0, 32'h0,        1'b1, 32'h40};
    vt[13] = '{1'b1, 32'h40,  1'b0, 1'b1, 32'h0,        1'b1, 32'h22222222, 1'b0, 32'h40};
    vt[14] = '{1'b1, 32'h100, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h40};
    vt[15] = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h33333333, 1'b0, 32'h0,        1'b1, 32'h100};
    vt[16] = '{1'b1, 32'h100, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h100};
    vt[17] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h44444444, 1'b0, 32'h0,        1'b1, 32'h100};
    vt[18] = '{1'b1, 32'h100, 1'b0, 1'b1, 32'h0,        1'b1, 32'h44444444, 1'b0, 32'h100};
    vt[19] = '{1'b1, 32'h100, 1'b1, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h100};
    vt[20] = '{1'b1, 32'h100, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h100};
    vt[21] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h55555555, 1'b0, 32'h0,        1'b1, 32'h100};
    vt[22] = '{1'b0, 32'h100, 1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        1'b0, 32'h100};

    nRST = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
    #2;
    chk("rst_ihit",     {31'h0, bus.ihit}, 32'h0);
    chk("rst_imemload", bus.imemload,      32'h0);
    chk("rst_iREN",     {31'h0, bus.iREN}, 32'h0);
    chk("rst_iaddr",    bus.iaddr,         32'h0);
    #10 nRST = 1'b1;
    @(posedge CLK); #1;

    // Table: inputs set 1 time unit after the edge, outputs sampled at the falling edge.
    for (int i = 0; i < 23; i++) begin
      drive(vt[i].ren, vt[i].addr, vt[i].flush, vt[i].iwait, vt[i].iload);
      #4;
      chk($sformatf("v%0d_ihit", i),     {31'h0, bus.ihit}, {31'h0, vt[i].e_hit});
      chk($sformatf("v%0d_imemload", i), bus.imemload,      vt[i].e_load);
      chk($sformatf("v%0d_iREN", i),     {31'h0, bus.iREN}, {31'h0, vt[i].e_ren});
      chk($sformatf("v%0d_iaddr", i),    bus.iaddr,         vt[i].e_iaddr);
      @(posedge CLK); #1;
    end

    // Reset asserted in FETCH with data ready: fill must be aborted.
    drive(1'b1, 32'h200, 1'b0, 1'b1, 32'h0);
    @(posedge CLK); #1;
    #3;
    chk("rf_iREN_fetch", {31'h0, bus.iREN}, 32'h1);
    chk("rf_iaddr_fetch", bus.iaddr, 32'h200);
    drive(1'b1, 32'h200, 1'b0, 1'b0, 32'hDEADBEEF);
    nRST = 1'b0;
    #1;
    chk("rf_iREN_rst",  {31'h0, bus.iREN}, 32'h0);
    chk("rf_iaddr_rst", bus.iaddr, 32'h0);
    chk("rf_ihit_rst",  {31'h0, bus.ihit}, 32'h0);
    @(posedge CLK); #1;
    drive(1'b0, 32'h200, 1'b0, 1'b1, 32'h0);
    nRST = 1'b1;
    @(posedge CLK); #1;
    drive(1'b1, 32'h200, 1'b0, 1'b1, 32'h0);
    #4;
    chk("rf_after_miss", {31'h0, bus.ihit}, 32'h0);
    @(posedge CLK); #1;
    drive(1'b1, 32'h200, 1'b0, 1'b0, 32'h00000066);
    @(posedge CLK); #1;
    drive(1'b1, 32'h200, 1'b0, 1'b1, 32'h0);
    #4;
    chk("rf_refill_hit",  {31'h0, bus.ihit}, 32'h1);
    chk("rf_refill_data", bus.imemload, 32'h00000066);
    @(posedge CLK); #1;

    // Variable memory latency on the last frame: hit lands latency+2 cycles after the request.
    lat       = $urandom_range(0, 4);
    hit_cycle = 99;
    hit_word  = 32'h0;
    for (int c = 0; c < 20; c++) begin
      drive(1'b1, 32'h3C, 1'b0, (c == lat + 1) ? 1'b0 : 1'b1, 32'hCAFEF00D);
      #4;
      if (c == 1) chk("lat_iaddr", bus.iaddr, 32'h3C);
      if (bus.ihit && hit_cycle == 99) begin
        hit_cycle = c;
        hit_word  = bus.imemload;
      end
      @(posedge CLK); #1;
    end
    chk("lat_hit_cycle", hit_cycle, lat + 2);
    chk("lat_hit_data",  hit_word,  32'hCAFEF00D);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0);

`ifdef ICACHE_STATS_EN
    nRST = 1'b0;
    #2;
    chk("st_rst_hits",   bus.hit_count,  32'h0);
    chk("st_rst_misses", bus.miss_count, 32'h0);
    nRST = 1'b1;
    @(posedge CLK); #1;
    drive(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
    @(posedge CLK); #1;
    drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h12345678);
    @(posedge CLK); #1;
    drive(1'b1, 32'h40, 1'b0, 1'b1, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK); #1;
    end
    drive(1'b0, 32'h40, 1'b0, 1'b1, 32'h0);
    #4;
    chk("st_hits",   bus.hit_count,  32'd3);
    chk("st_misses", bus.miss_count, 32'd1);
    @(posedge CLK); #1;
    drive(1'b0, 32'h40, 1'b1, 1'b1, 32'h0);
    @(posedge CLK); #1;
    drive(1'b0, 32'h40, 1'b0, 1'b1, 32'h0);
    #4;
    chk("st_flush_hits",   bus.hit_count,  32'd3);
    chk("st_flush_misses", bus.miss_count, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL provide parameter NSETS, default 16, number of direct-mapped one-word frames (power of two, 2..64).
REQ-002 SHALL derive IDXW = log2(NSETS) and TAGW = 30 - IDXW internally; no other parameters.
REQ-003 SHALL have port CLK  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imemREN  input  1  datapath fetch request.
REQ-006 SHALL have port imemaddr  input  32  datapath fetch byte address (PC).
REQ-007 SHALL have port ihit  output  1  fetch word valid this cycle.
REQ-008 SHALL have port imemload  output  32  fetched instruction word.
REQ-009 SHALL have port flush  input  1  synchronous invalidate-all request.
REQ-010 SHALL have port iREN  output  1  memory-side read request.
REQ-011 SHALL have port iaddr  output  32  memory-side word-aligned read address.
REQ-012 SHALL have port iwait  input  1  memory busy; iwait=0 while iREN=1 means iload valid this cycle.
REQ-013 SHALL have port iload  input  32  memory read data.

Function
REQ-014 SHALL split imemaddr as tag=[31:IDXW+2], index=[IDXW+1:2]; bits [1:0] ignored.
REQ-015 SHALL store per frame: valid (1), tag (TAGW), data (32).
REQ-016 SHALL implement FSM states IDLE and FETCH.
REQ-017 In IDLE, ihit SHALL be combinational: imemREN & valid[index] & tag match; imemload = frame data when ihit=1, else 32'h0.
REQ-018 In IDLE, imemREN=1 with no hit SHALL latch imemaddr into miss_addr and transition to FETCH next edge; ihit=0 that cycle.
REQ-019 In FETCH, iREN SHALL be 1, iaddr SHALL be {miss_addr[31:2],2'b00}, ihit SHALL be 0.
REQ-020 In FETCH with iwait=0, SHALL write iload, miss_addr tag and valid=1 into frame miss_addr index and return to IDLE; refetched word hits in the following IDLE cycle (miss penalty = memory latency + 1 cycle).
REQ-021 In FETCH with iwait=1, SHALL hold state and miss_addr; changes on imemaddr SHALL NOT alter the in-flight fill.
REQ-022 iREN SHALL be 0 in IDLE; imemREN=0 SHALL force ihit=0 and no miss.
REQ-023 flush=1 SHALL clear every valid bit at the next edge and force state IDLE; an in-progress fill SHALL be abandoned and NOT written, even if iwait=0 that same cycle.
REQ-024 flush=1 SHALL force ihit=0 in that cycle.
REQ-025 A fill to an already-valid frame SHALL overwrite tag and data (replacement without eviction traffic).

Reset
REQ-026 nRST=0 SHALL asynchronously set state IDLE, all valid bits 0, miss_addr 0; tags/data need not reset.
REQ-027 Outputs during/after reset SHALL be ihit=0, imemload=0, iREN=0, iaddr=0 until the first request.
REQ-028 Reset during FETCH SHALL abort the fill; no frame written.

Configuration
REQ-029 With macro ICACHE_STATS_EN defined, SHALL add outputs hit_count (32) and miss_count (32), reset to 0.
REQ-030 With ICACHE_STATS_EN, hit_count SHALL increment each cycle ihit=1; miss_count SHALL increment on each IDLE->FETCH transition; both saturate at 32'hFFFFFFFF; flush SHALL NOT clear them.
REQ-031 Without ICACHE_STATS_EN, the counter ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-032 Cold miss: reset, imemaddr=0x00000040, imemREN=1, memory iwait=1 for 2 cycles then iload=0x8C220004 -> iREN=1 with iaddr=0x40 for 3 cycles, ihit=1 imemload=0x8C220004 the cycle after.
REQ-033 Hit: repeat 0x40 after fill -> ihit=1 same cycle, iREN stays 0.
REQ-034 Conflict (NSETS=16): fill 0x40 then 0x80 (same index 0) -> second is miss; 0x40 then misses again.
REQ-035 Flush mid-fill: in FETCH assert flush with iwait=0 -> state IDLE, frame not valid, next access to same address misses.
REQ-036 Address change mid-miss: imemaddr 0x40 -> 0x100 while iwait=1 -> iaddr stays 0x40 until fill, then 0x100 misses.
REQ-037 With ICACHE_STATS_EN: 1 miss then 3 hit cycles -> miss_count=1, hit_count=3; flush leaves both unchanged.
